bsg_manycore_mem_responder: RTL and testbench
=============================================

# bsg_manycore_mem_responder

Edge-of-mesh endpoint that services remote load/store request packets issued by tile processors and returns one response packet per request. It sits on a stubbed mesh port (typically south of the bottom row), behind the router's processor-side link. Tiles act as initiators and this block is the responder. Word-addressed local storage is held in a single-port synchronous SRAM.

## Interface
- x_cord_width_p, -1: X coordinate width; must be set.
- y_cord_width_p, -1: Y coordinate width; must be set.
- data_width_p, 32: data word width; multiple of 8.
- addr_width_p, -1: request word-address width; must be set.
- mem_els_p, 1024: SRAM depth in words; power of two, at most 2^addr_width_p.
- clk_i  in  1  sole clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- my_x_i  in  x_cord_width_p  this endpoint's X coordinate.
- my_y_i  in  y_cord_width_p  this endpoint's Y coordinate.
- req_v_i  in  1  request valid.
- req_packet_i  in  req_packet_s  fields: op[1:0], addr, data, mask (data_width_p/8 bits), src_x, src_y.
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o.
- resp_v_o  out  1  response valid.
- resp_packet_o  out  resp_packet_s  fields: type[1:0], data, dst_x, dst_y, src_x, src_y.
- resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i.

## Operation
- Requests enter a 2-entry FIFO. req_ready_o = FIFO not full.
- Op encoding: 0 = load, 1 = store, 2/3 = illegal.
- Response type encoding: 0 = load data, 1 = store ack, 2 = error.
- FSM has two states: IDLE and RESP.
- IDLE: if FIFO non-empty, dequeue the head, issue its SRAM operation, latch header/type into the response register, go to RESP. Otherwise stay in IDLE.
- RESP: resp_v_o = 1.
  - On handshake with FIFO non-empty: dequeue and issue the next request in the same cycle, stay in RESP.
  - On handshake with FIFO empty: go to IDLE.
  - No handshake: hold. resp_packet_o stays stable and no SRAM access is issued.
- Load: SRAM read at addr[lg(mem_els_p)-1:0]. resp data = SRAM read data.
- Store: byte-masked write of data using mask. resp data = 0, type 1. A mask of 0 writes nothing but is still acked.
- Error: addr >= mem_els_p or illegal op. No SRAM access, type 2, data = 0.
- Response routing: dst_x/dst_y = request src_x/src_y. src_x/src_y = my_x_i/my_y_i, sampled at dequeue.
- Exactly one response per accepted request, in acceptance order.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): FSM = IDLE, FIFO empty, resp_v_o = 0, resp_packet_o = 0, req_ready_o = 0 while reset_n_i is low. SRAM contents are not reset.
- After reset deassert, req_ready_o = 1 on the first clock edge.
- Latency: request accepted at edge N; dequeue and SRAM access in cycle N+1; resp_v_o = 1 in cycle N+2.
- Throughput: one response per cycle when resp_ready_i is held at 1.
- FIFO full (2 entries while stalled in RESP): req_ready_o = 0 until a dequeue. Enqueue and dequeue in the same cycle on a full FIFO are legal.
- Simultaneous enqueue into an empty FIFO while in IDLE: the new entry is dequeued in the following cycle. There is no bypass.
- A load following a store to the same address returns the stored data. The write completes before the next access.
- Reset asserted mid-operation: pending and in-flight requests are dropped without a response.

## Structure
- Package bsg_manycore_mem_responder_pkg holds:
  - the req_packet_s and resp_packet_s typedefs, parameterized via macros on the width parameters;
  - op and response-type enums;
  - the state enum.
- Sub-module bsg_manycore_mem_responder_fifo: 2-entry FIFO with async active-low reset, valid/ready on both sides.
- The SRAM is an instance of bsg_mem_1rw_sync_mask_write_byte with els_p = mem_els_p.

## Test plan
- Store to addr 0x10, data 0xDEADBEEF, mask 0xF, src (2,3), then load addr 0x10 -> ack (type 1, dst (2,3)), then load data 0xDEADBEEF at cycle N+2 after acceptance.
- Store data 0x11223344, mask 0x5, over existing 0xAAAAAAAA -> subsequent load returns 0xAA22AA44.
- Load addr 1024 with mem_els_p = 1024, and op = 3 -> two type-2 responses with data 0; SRAM unchanged.
- Hold resp_ready_i = 0 and drive 4 requests -> 3 accepted (1 in RESP, 2 in FIFO), req_ready_o = 0. Response held stable; release gives in-order responses, one per cycle.
- 100 random back-to-back requests with resp_ready_i = 1 -> 100 responses, one per cycle after fill, matching a reference-memory model.
- Assert reset_n_i with 2 requests queued -> resp_v_o = 0 immediately. After release: no stale responses, req_ready_o = 1, prior SRAM data intact.

Source files
------------

// File: rtl/bsg_manycore_mem_responder_pkg.sv
// Packet layouts, opcode/response encodings and FSM states shared by the responder,
// its interface and anything that builds packets for it.
`ifndef BSG_MANYCORE_MEM_RESPONDER_PKG_SV
`define BSG_MANYCORE_MEM_RESPONDER_PKG_SV

// Packets depend on the mesh/width parameters, so they are stamped out per user.
`define BSG_MANYCORE_MEM_RESPONDER_REQ_PACKET_S(x_w, y_w, d_w, a_w) \
    typedef struct packed {              \
        logic [1:0]           op;        \
        logic [(a_w)-1:0]     addr;      \
        logic [(d_w)-1:0]     data;      \
        logic [((d_w)/8)-1:0] mask;      \
        logic [(x_w)-1:0]     src_x;     \
        logic [(y_w)-1:0]     src_y;     \
    } req_packet_s

// 'type' is a keyword, hence resp_type.
`define BSG_MANYCORE_MEM_RESPONDER_RESP_PACKET_S(x_w, y_w, d_w) \
    typedef struct packed {              \
        logic [1:0]           resp_type; \
        logic [(d_w)-1:0]     data;      \
        logic [(x_w)-1:0]     dst_x;     \
        logic [(y_w)-1:0]     dst_y;     \
        logic [(x_w)-1:0]     src_x;     \
        logic [(y_w)-1:0]     src_y;     \
    } resp_packet_s

package bsg_manycore_mem_responder_pkg;

    typedef enum logic [1:0] {
        e_op_load  = 2'd0,
        e_op_store = 2'd1
    } op_e;

    typedef enum logic [1:0] {
        e_resp_load      = 2'd0,
        e_resp_store_ack = 2'd1,
        e_resp_error     = 2'd2
    } resp_type_e;

    typedef enum logic {
        e_idle = 1'b0,
        e_resp = 1'b1
    } state_e;

    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == e_op_load) || (op == e_op_store);
    endfunction

endpackage

`endif

// File: rtl/bsg_manycore_mem_responder_if.sv
// Request/response handshake bundle between a mesh link (master) and the responder (slave).
interface bsg_manycore_mem_responder_if
    import bsg_manycore_mem_responder_pkg::*;
#(
    parameter int x_cord_width_p = -1,
    parameter int y_cord_width_p = -1,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = -1
) ();

    `BSG_MANYCORE_MEM_RESPONDER_REQ_PACKET_S(x_cord_width_p, y_cord_width_p, data_width_p, addr_width_p);
    `BSG_MANYCORE_MEM_RESPONDER_RESP_PACKET_S(x_cord_width_p, y_cord_width_p, data_width_p);

    logic         req_v_i;
    req_packet_s  req_packet_i;
    logic         req_ready_o;
    logic         resp_v_o;
    resp_packet_s resp_packet_o;
    logic         resp_ready_i;

    modport master (
        output req_v_i, req_packet_i, resp_ready_i,
        input  req_ready_o, resp_v_o, resp_packet_o
    );

    modport slave (
        input  req_v_i, req_packet_i, resp_ready_i,
        output req_ready_o, resp_v_o, resp_packet_o
    );

endinterface

// File: rtl/bsg_manycore_mem_responder_fifo.sv
// Two-entry valid/ready FIFO; ready stays low until the first clock edge after reset.
module bsg_manycore_mem_responder_fifo #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic [1:0][width_p-1:0] mem_q, mem_d;
    logic                    wptr_q, wptr_d;
    logic                    rptr_q, rptr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    en_q;
    logic                    enq, deq;

    assign ready_o = en_q & (cnt_q != 2'd2);
    assign v_o     = (cnt_q != 2'd0);
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = v_o & ready_i;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (enq) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = ~wptr_q;
        end
        if (deq) begin
            rptr_d = ~rptr_q;
        end
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q  <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
            en_q   <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            en_q   <= 1'b1;
        end
    end

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous SRAM with per-byte write enables; read data holds until the next read.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int els_p        = 2,
    parameter int data_width_p = 32,
    parameter int addr_width_p = $clog2(els_p)
) (
    input  logic                        clk_i,
    input  logic                        v_i,
    input  logic                        w_i,
    input  logic [addr_width_p-1:0]     addr_i,
    input  logic [data_width_p-1:0]     data_i,
    input  logic [(data_width_p/8)-1:0] write_mask_i,
    output logic [data_width_p-1:0]     data_o
);

    logic [data_width_p-1:0] mem_q [els_p];
    logic [data_width_p-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (v_i & w_i) begin
            for (int b = 0; b < data_width_p/8; b++) begin
                if (write_mask_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end
        if (v_i & ~w_i) begin
            data_q <= mem_q[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_manycore_mem_responder.sv
// Edge-of-mesh memory endpoint: queues remote load/store packets, services them against a
// byte-maskable sync SRAM and returns exactly one response per request, in acceptance order.
module bsg_manycore_mem_responder
    import bsg_manycore_mem_responder_pkg::*;
#(
    parameter int x_cord_width_p = -1,
    parameter int y_cord_width_p = -1,
    parameter int data_width_p   = 32,
    parameter int addr_width_p   = -1,
    parameter int mem_els_p      = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [x_cord_width_p-1:0]   my_x_i,
    input  logic [y_cord_width_p-1:0]   my_y_i,
    bsg_manycore_mem_responder_if.slave io
);

    localparam int lg_els_lp = $clog2(mem_els_p);

    `BSG_MANYCORE_MEM_RESPONDER_REQ_PACKET_S(x_cord_width_p, y_cord_width_p, data_width_p, addr_width_p);
    `BSG_MANYCORE_MEM_RESPONDER_RESP_PACKET_S(x_cord_width_p, y_cord_width_p, data_width_p);

    req_packet_s             head;
    logic                    head_v;
    logic                    fifo_ready_li;
    logic                    deq;
    logic                    addr_oor;
    logic                    req_err;
    logic [data_width_p-1:0] sram_data;

    state_e       state_q, state_d;
    resp_packet_s resp_q, resp_d;
    logic         is_load_q, is_load_d;
    resp_packet_s resp_out;

    bsg_manycore_mem_responder_fifo #(
        .width_p($bits(req_packet_s))
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (io.req_v_i),
        .data_i    (io.req_packet_i),
        .ready_o   (io.req_ready_o),
        .v_o       (head_v),
        .data_o    (head),
        .ready_i   (fifo_ready_li)
    );

    // The head may only leave when the response register is free or being drained.
    assign fifo_ready_li = (state_q == e_idle) | io.resp_ready_i;
    assign deq           = head_v & fifo_ready_li;

    if (addr_width_p > lg_els_lp) begin : g_oor
        assign addr_oor = |head.addr[addr_width_p-1:lg_els_lp];
    end else begin : g_no_oor
        assign addr_oor = 1'b0;
    end

    assign req_err = ~op_is_legal(head.op) | addr_oor;

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (mem_els_p),
        .data_width_p (data_width_p),
        .addr_width_p (lg_els_lp)
    ) sram (
        .clk_i        (clk_i),
        .v_i          (deq & ~req_err),
        .w_i          (head.op == e_op_store),
        .addr_i       (head.addr[lg_els_lp-1:0]),
        .data_i       (head.data),
        .write_mask_i (head.mask),
        .data_o       (sram_data)
    );

    always_comb begin
        state_d   = state_q;
        resp_d    = resp_q;
        is_load_d = is_load_q;

        if (state_q == e_idle) begin
            if (head_v) begin
                state_d = e_resp;
            end
        end else begin
            if (io.resp_ready_i) begin
                state_d = head_v ? e_resp : e_idle;
            end
        end

        if (deq) begin
            if (req_err) begin
                resp_d.resp_type = e_resp_error;
            end else if (head.op == e_op_load) begin
                resp_d.resp_type = e_resp_load;
            end else begin
                resp_d.resp_type = e_resp_store_ack;
            end
            resp_d.data  = '0;
            resp_d.dst_x = head.src_x;
            resp_d.dst_y = head.src_y;
            resp_d.src_x = my_x_i;
            resp_d.src_y = my_y_i;
            is_load_d    = ~req_err & (head.op == e_op_load);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            resp_q    <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            resp_q    <= resp_d;
            is_load_q <= is_load_d;
        end
    end

    // Load data comes straight from the SRAM output latch, which no access disturbs while stalled.
    always_comb begin
        resp_out = resp_q;
        if (is_load_q) begin
            resp_out.data = sram_data;
        end
    end

    assign io.resp_v_o      = (state_q == e_resp);
    assign io.resp_packet_o = resp_out;

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Directed-vector and corner-sequence bench for bsg_manycore_mem_responder.
module tb_bsg_manycore_mem_responder;
    import bsg_manycore_mem_responder_pkg::*;

    localparam int XW  = 4;
    localparam int YW  = 4;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int ELS = 1024;
    localparam int NV  = 15;
    localparam int NR  = 100;

    `BSG_MANYCORE_MEM_RESPONDER_REQ_PACKET_S(XW, YW, DW, AW);
    `BSG_MANYCORE_MEM_RESPONDER_RESP_PACKET_S(XW, YW, DW);

    typedef struct {
        req_packet_s pkt;
        logic [1:0]  etype;
        logic [31:0] edata;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [XW-1:0] my_x = 4'd5;
    logic [YW-1:0] my_y = 4'd6;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    bsg_manycore_mem_responder_if #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW), .addr_width_p(AW)
    ) bus ();

    bsg_manycore_mem_responder #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .mem_els_p(ELS)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .my_x_i    (my_x),
        .my_y_i    (my_y),
        .io        (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic req_packet_s mk_pkt(input logic [1:0] op, input logic [AW-1:0] a,
                                           input logic [31:0] d, input logic [3:0] m,
                                           input logic [XW-1:0] sx, input logic [YW-1:0] sy);
        req_packet_s p;
        p.op = op; p.addr = a; p.data = d; p.mask = m; p.src_x = sx; p.src_y = sy;
        return p;
    endfunction

    function automatic vec_t mkv(input logic [1:0] op, input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic [3:0] m, input logic [3:0] sx, input logic [3:0] sy,
                                 input logic [1:0] et, input logic [31:0] ed);
        vec_t v;
        v.pkt = mk_pkt(op, a, d, m, sx, sy);
        v.etype = et;
        v.edata = ed;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input req_packet_s p, output bit ok);
        ok = 1'b0;
        bus.req_v_i      = 1'b1;
        bus.req_packet_i = p;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_ready_o;
            @(posedge clk); #1;
        end
        bus.req_v_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept: request not accepted within 20 cycles");
        end
    endtask

    task automatic do_vec(input string name, input vec_t v);
        bit           ok;
        int           lat;
        resp_packet_s r;
        send(v.pkt, ok);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.resp_v_o) lat = i;
        end
        r = bus.resp_packet_o;
        check({name, " latency"}, 64'(lat), 64'd2);
        check({name, " type"},    64'(r.resp_type), 64'(v.etype));
        check({name, " data"},    64'(r.data), 64'(v.edata));
        check({name, " dst"},     64'({r.dst_x, r.dst_y}), 64'({v.pkt.src_x, v.pkt.src_y}));
        check({name, " src"},     64'({r.src_x, r.src_y}), 64'({my_x, my_y}));
        @(posedge clk); #1;
    endtask

    // Holds req_v over 'cycles' cycles, advancing through pk[] on each acceptance.
    task automatic push_burst(input req_packet_s pk[4], input int limit, input int cycles,
                              output int accepted);
        bit acc;
        accepted         = 0;
        bus.req_v_i      = 1'b1;
        bus.req_packet_i = pk[0];
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            acc = bus.req_ready_o & bus.req_v_i;
            @(posedge clk); #1;
            if (acc) begin
                accepted++;
                if (accepted < limit) bus.req_packet_i = pk[accepted];
                else bus.req_v_i = 1'b0;
            end
        end
        bus.req_v_i = 1'b0;
    endtask

    vec_t         vecs[NV];
    req_packet_s  pk[4];
    req_packet_s  rp[NR];
    logic [1:0]   et[NR];
    logic [31:0]  ed[NR];
    logic [31:0]  ref_mem[8];
    resp_packet_s snap;
    int           acc_n;
    int           seen;

    initial begin
        bus.req_v_i      = 1'b0;
        bus.req_packet_i = '0;
        bus.resp_ready_i = 1'b1;

        // ---- reset state ----
        #12;
        check("reset resp_v", 64'(bus.resp_v_o), 64'd0);
        check("reset req_ready", 64'(bus.req_ready_o), 64'd0);
        check("reset resp_packet", 64'(bus.resp_packet_o), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        check("post-reset req_ready", 64'(bus.req_ready_o), 64'd1);
        @(posedge clk); #1;

        // ---- directed vectors ----
        vecs[0]  = mkv(2'd1, 12'h010, 32'hDEADBEEF, 4'hF,  2,  3, 2'd1, 32'h0);
        vecs[1]  = mkv(2'd0, 12'h010, 32'h0,        4'h0,  2,  3, 2'd0, 32'hDEADBEEF);
        vecs[2]  = mkv(2'd1, 12'h020, 32'hAAAAAAAA, 4'hF,  1,  7, 2'd1, 32'h0);
        vecs[3]  = mkv(2'd1, 12'h020, 32'h11223344, 4'h5,  1,  7, 2'd1, 32'h0);
        vecs[4]  = mkv(2'd0, 12'h020, 32'h0,        4'h0,  9,  0, 2'd0, 32'hAA22AA44);
        vecs[5]  = mkv(2'd0, 12'h400, 32'h0,        4'h0,  3,  3, 2'd2, 32'h0);
        vecs[6]  = mkv(2'd3, 12'h010, 32'h12345678, 4'hF,  4,  1, 2'd2, 32'h0);
        vecs[7]  = mkv(2'd0, 12'h010, 32'h0,        4'h0,  4,  1, 2'd0, 32'hDEADBEEF);
        vecs[8]  = mkv(2'd1, 12'h3FF, 32'h01020304, 4'hF, 15, 15, 2'd1, 32'h0);
        vecs[9]  = mkv(2'd1, 12'h3FF, 32'hCAFEF00D, 4'h0,  0,  0, 2'd1, 32'h0);
        vecs[10] = mkv(2'd0, 12'h3FF, 32'h0,        4'h0,  7,  8, 2'd0, 32'h01020304);
        vecs[11] = mkv(2'd2, 12'h020, 32'hFFFFFFFF, 4'hF,  6,  2, 2'd2, 32'h0);
        vecs[12] = mkv(2'd1, 12'h020, 32'h55667788, 4'h8,  6,  2, 2'd1, 32'h0);
        vecs[13] = mkv(2'd0, 12'h020, 32'h0,        4'h0,  6,  2, 2'd0, 32'h5522AA44);
        vecs[14] = mkv(2'd1, 12'hFFF, 32'h0,        4'hF,  1,  1, 2'd2, 32'h0);
        for (int i = 0; i < NV; i++) do_vec($sformatf("vec%0d", i), vecs[i]);

        // ---- backpressure: 4 offered, 3 held (1 in RESP, 2 queued) ----
        bus.resp_ready_i = 1'b0;
        pk[0] = mk_pkt(2'd0, 12'h010, 32'h0, 4'h0, 1, 1);
        pk[1] = mk_pkt(2'd0, 12'h020, 32'h0, 4'h0, 2, 2);
        pk[2] = mk_pkt(2'd0, 12'h3FF, 32'h0, 4'h0, 3, 3);
        pk[3] = mk_pkt(2'd1, 12'h010, 32'h0BADF00D, 4'hF, 4, 4);
        push_burst(pk, 4, 8, acc_n);
        check("stall accepted", 64'(acc_n), 64'd3);
        @(negedge clk);
        check("stall req_ready", 64'(bus.req_ready_o), 64'd0);
        check("stall resp_v", 64'(bus.resp_v_o), 64'd1);
        snap = bus.resp_packet_o;
        check("stall head data", 64'(snap.data), 64'hDEADBEEF);
        repeat (3) @(negedge clk);
        check("stall stable", 64'(bus.resp_packet_o), 64'(snap));
        @(posedge clk); #1;
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        check("drain0 v/data/dst", {bus.resp_v_o, bus.resp_packet_o.data, bus.resp_packet_o.dst_x},
              {1'b1, 32'hDEADBEEF, 4'd1});
        @(negedge clk);
        check("drain1 v/data/dst", {bus.resp_v_o, bus.resp_packet_o.data, bus.resp_packet_o.dst_x},
              {1'b1, 32'h5522AA44, 4'd2});
        @(negedge clk);
        check("drain2 v/data/dst", {bus.resp_v_o, bus.resp_packet_o.data, bus.resp_packet_o.dst_x},
              {1'b1, 32'h01020304, 4'd3});
        @(negedge clk);
        check("drain done resp_v", 64'(bus.resp_v_o), 64'd0);
        @(posedge clk); #1;

        // ---- random back-to-back against a reference model (addr 0..7 + out of range) ----
        for (int i = 0; i < NR; i++) begin
            logic [1:0]    op;
            logic [AW-1:0] a;
            logic [31:0]   d;
            logic [3:0]    m;
            if (i < 8) begin
                op = 2'd1; a = AW'(i); m = 4'hF;
            end else begin
                op = 2'($urandom_range(0, 3));
                a  = ($urandom_range(0, 9) == 0) ? AW'(12'h400 + $urandom_range(0, 255))
                                                 : AW'($urandom_range(0, 7));
                m  = 4'($urandom_range(0, 15));
            end
            d = $urandom;
            rp[i] = mk_pkt(op, a, d, m, 4'(i), 4'(i / 16));
            if (op > 2'd1 || a >= AW'(ELS)) begin
                et[i] = 2'd2; ed[i] = 32'h0;
            end else if (op == 2'd0) begin
                et[i] = 2'd0; ed[i] = ref_mem[a[2:0]];
            end else begin
                et[i] = 2'd1; ed[i] = 32'h0;
                for (int b = 0; b < 4; b++)
                    if (m[b]) ref_mem[a[2:0]][b*8 +: 8] = d[b*8 +: 8];
            end
        end
        fork
            begin : sender
                int  k;
                bit  acc;
                k = 0;
                bus.req_v_i      = 1'b1;
                bus.req_packet_i = rp[0];
                for (int c = 0; c < 400 && k < NR; c++) begin
                    @(negedge clk);
                    acc = bus.req_ready_o;
                    @(posedge clk); #1;
                    if (acc) begin
                        k++;
                        if (k < NR) bus.req_packet_i = rp[k];
                    end
                end
                bus.req_v_i = 1'b0;
                check("rand sent", 64'(k), 64'(NR));
            end
            begin : collector
                int           n;
                int           first;
                int           last;
                resp_packet_s r;
                n = 0; first = 0; last = 0;
                for (int c = 1; c <= 600 && n < NR; c++) begin
                    @(negedge clk);
                    if (bus.resp_v_o) begin
                        r = bus.resp_packet_o;
                        check($sformatf("rand%0d", n), {r.resp_type, r.data, r.dst_x, r.dst_y},
                              {et[n], ed[n], rp[n].src_x, rp[n].src_y});
                        if (n == 0) first = c;
                        last = c;
                        n++;
                    end
                end
                check("rand responses", 64'(n), 64'(NR));
                check("rand throughput span", 64'(last - first), 64'(NR - 1));
            end
        join
        @(posedge clk); #1;

        // ---- reset with a response pending and two requests queued ----
        bus.resp_ready_i = 1'b0;
        pk[0] = mk_pkt(2'd0, 12'h010, 32'h0, 4'h0, 1, 2);
        pk[1] = mk_pkt(2'd1, 12'h010, 32'hBAD0BAD0, 4'hF, 1, 2);
        pk[2] = mk_pkt(2'd1, 12'h010, 32'hBAD0BAD0, 4'hF, 1, 2);
        pk[3] = pk[2];
        push_burst(pk, 3, 5, acc_n);
        check("prereset accepted", 64'(acc_n), 64'd3);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("midreset resp_v", 64'(bus.resp_v_o), 64'd0);
        check("midreset req_ready", 64'(bus.req_ready_o), 64'd0);
        check("midreset resp_packet", 64'(bus.resp_packet_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.resp_ready_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.resp_v_o) seen++;
        end
        check("stale responses", 64'(seen), 64'd0);
        check("after reset req_ready", 64'(bus.req_ready_o), 64'd1);
        @(posedge clk); #1;
        do_vec("sram kept", mkv(2'd0, 12'h010, 32'h0, 4'h0, 8, 9, 2'd0, 32'hDEADBEEF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
